// File: rtl/eth_sw_pkg.sv
// rtl/eth_sw_pkg.sv - shared types and defaults for the switch receive path
package eth_sw_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_MIN_FRAME_LEN = 64;
  localparam int DEF_MAX_FRAME_LEN = 1518;

  typedef enum logic [1:0] {
    SOF  = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      err;
  } rx_entry_t;

  // len counts beats already accepted; the beat now landing is beat len+1
  function automatic logic len_below(input logic [15:0] len, input int lim);
    return (int'(len) + 1) < lim;
  endfunction

  function automatic logic len_reaches(input logic [15:0] len, input int lim);
    return (int'(len) + 1) == lim;
  endfunction

endpackage

// File: rtl/rx_frame_reader_buf.sv
// rtl/rx_frame_reader_buf.sv - 3-entry output buffer with push/pop and occupancy
module rx_frame_reader_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_occ
);

  localparam logic [1:0] DEPTH = 2'd3;

  logic [WIDTH-1:0] r_mem [3];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_occ;
  logic             w_push;
  logic             w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != DEPTH) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_occ    <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_push && (r_wr_ptr == 2'(i))) r_mem[i] <= i_push_data;
      end
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_comb begin
    o_head = r_mem[0];
    if (r_rd_ptr == 2'd1)      o_head = r_mem[1];
    else if (r_rd_ptr == 2'd2) o_head = r_mem[2];
  end

  assign o_occ = r_occ;

endmodule

// File: rtl/rx_frame_reader.sv
// rtl/rx_frame_reader.sv - FIFO drain to framed byte stream; stats under RX_FRAME_READER_STATS_EN
module rx_frame_reader
  import eth_sw_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
  parameter int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH:0]   fifo_r_data,
  input  logic                  fifo_r_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_err
`ifdef RX_FRAME_READER_STATS_EN
  ,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           err_cnt
`endif
);

  localparam int EW = DATA_WIDTH + 2;

  logic            r_rd_pending;
  rx_state_e       r_state;
  logic [15:0]     r_len;

  logic [1:0]      w_occ;
  logic [EW-1:0]   w_head;
  logic            w_land_last;
  logic            w_len_runt;
  logic            w_len_max;
  logic            w_push;
  logic            w_push_last;
  logic            w_push_err;
  logic            w_pop;

  assign w_land_last = fifo_r_data[DATA_WIDTH];
  assign w_len_runt  = len_below(r_len, MIN_FRAME_LEN);
  assign w_len_max   = len_reaches(r_len, MAX_FRAME_LEN);

  // Only registered occupancy terms gate the read so m_ready never reaches fifo_r_en
  assign fifo_r_en = rrst_n && !fifo_r_empty &&
                     (({1'b0, w_occ} + {2'b00, r_rd_pending}) <= 3'd2);

  always_comb begin
    w_push      = r_rd_pending && (r_state != DROP);
    w_push_last = w_land_last || w_len_max;
    w_push_err  = w_land_last ? w_len_runt : w_len_max;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rd_pending <= 1'b0;
      r_state      <= SOF;
      r_len        <= 16'd0;
    end else begin
      r_rd_pending <= fifo_r_en;
      if (r_rd_pending) begin
        case (r_state)
          SOF, BODY: begin
            if (w_land_last) begin
              r_len   <= 16'd0;
              r_state <= SOF;
            end else if (w_len_max) begin
              r_len   <= 16'd0;
              r_state <= DROP;
            end else begin
              r_len   <= r_len + 16'd1;
              r_state <= BODY;
            end
          end
          DROP: begin
            if (w_land_last) r_state <= SOF;
          end
          default: begin
            r_len   <= 16'd0;
            r_state <= SOF;
          end
        endcase
      end
    end
  end

  assign w_pop   = m_valid && m_ready;
  assign m_valid = (w_occ != 2'd0);
  assign m_data  = w_head[EW-1:2];
  assign m_last  = w_head[1];
  assign m_err   = w_head[0];

  rx_frame_reader_buf #(
    .WIDTH(EW)
  ) u_buf (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .i_push      (w_push),
    .i_push_data ({fifo_r_data[DATA_WIDTH-1:0], w_push_last, w_push_err}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

`ifdef RX_FRAME_READER_STATS_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] r_err_cnt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_frame_cnt <= 32'd0;
      r_err_cnt   <= 32'd0;
    end else if (w_push && w_push_last) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_push_err) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_rx_frame_reader.sv
// tb/tb_rx_frame_reader.sv - self-checking bench for rx_frame_reader
module tb_rx_frame_reader;

  localparam int DW   = 8;
  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic          clk = 1'b0;
  logic          rrst_n;
  logic          fifo_r_en;
  logic [DW:0]   fifo_r_data;
  logic          fifo_r_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_err;
`ifdef RX_FRAME_READER_STATS_EN
  logic [31:0]   frame_cnt;
  logic [31:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  rx_frame_reader #(
    .DATA_WIDTH(DW), .MIN_FRAME_LEN(MINL), .MAX_FRAME_LEN(MAXL)
  ) dut (
    .rclk         (clk),
    .rrst_n       (rrst_n),
    .fifo_r_en    (fifo_r_en),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_empty (fifo_r_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_err        (m_err)
`ifdef RX_FRAME_READER_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       kept;
    logic       olast;
    logic       oerr;
  } src_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    int len;
    int rdy_pct;
    int gap_pct;
    int exp_beats;
    int exp_err;
  } row_t;

  src_t        src_q[$];
  beat_t       exp_q[$];
  src_t        staged;
  int          occ_m;
  bit          pend_m;
  int          gap_pct;
  int          rdy_pct;
  int          cyc;
  bit          hold_prev;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic        prev_err;
  int          fbeats;
  int          last_frame_beats;
  logic        last_frame_err;
  int          frames_seen;
  int          first_en_cyc;
  int          first_val_cyc;
  logic [31:0] fcnt_m;
  logic [31:0] ecnt_m;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference framing: first MAXL entries kept, frame closes on its own last or at MAXL
  task automatic add_frame(input int len);
    src_t s;
    for (int i = 0; i < len; i++) begin
      s.data  = 8'($urandom);
      s.last  = (i == len - 1);
      s.kept  = (i < MAXL);
      s.olast = ((i == len - 1) && (len <= MAXL)) || ((i == MAXL - 1) && (len > MAXL));
      s.oerr  = s.olast && ((len < MINL) || (len > MAXL));
      src_q.push_back(s);
      if (s.kept) exp_q.push_back('{data: s.data, last: s.olast, err: s.oerr});
    end
  endtask

  task automatic step();
    beat_t e;
    logic [8:0] junk;
    @(negedge clk);
    cyc++;
    junk = 9'($urandom);
    fifo_r_data  = pend_m ? {staged.last, staged.data} : junk;
    fifo_r_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    m_ready      = (int'($urandom_range(99)) < rdy_pct);
    #1;
    chk("fifo_r_en_rule", fifo_r_en, !fifo_r_empty && ((occ_m + int'(pend_m)) <= 2));
    chk("m_valid_occ", m_valid, occ_m != 0);
`ifdef RX_FRAME_READER_STATS_EN
    chk("frame_cnt", frame_cnt, fcnt_m);
    chk("err_cnt", err_cnt, ecnt_m);
`endif
    if (hold_prev) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
      chk("stall_err", m_err, prev_err);
    end
    if (fifo_r_en && first_en_cyc < 0) first_en_cyc = cyc;
    if (m_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e.data);
        chk("beat_last", m_last, e.last);
        chk("beat_err", m_err, e.err);
      end
      fbeats++;
      if (m_last) begin
        last_frame_beats = fbeats;
        last_frame_err   = m_err;
        frames_seen++;
        fbeats = 0;
      end
    end
    hold_prev = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    prev_err  = m_err;
    if (m_valid && m_ready && occ_m > 0) occ_m--;
    if (pend_m && staged.kept) begin
      occ_m++;
      if (staged.olast) begin
        fcnt_m++;
        if (staged.oerr) ecnt_m++;
      end
    end
    pend_m = fifo_r_en;
    if (fifo_r_en && src_q.size() != 0) staged = src_q.pop_front();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || pend_m || occ_m != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    occ_m     = 0;
    pend_m    = 1'b0;
    hold_prev = 1'b0;
    fbeats    = 0;
    fcnt_m    = 32'd0;
    ecnt_m    = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r_en"}, fifo_r_en, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_err"}, m_err, 0);
`ifdef RX_FRAME_READER_STATS_EN
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  row_t rows[10];

  initial begin
    int f0;
    int n;
    checks = 0; errors = 0; cyc = 0;
    frames_seen = 0; last_frame_beats = 0; last_frame_err = 1'b0;
    clear_model();
    rows[0] = '{len: 64,   rdy_pct: 100, gap_pct: 0,  exp_beats: 64,   exp_err: 0};
    rows[1] = '{len: 10,   rdy_pct: 100, gap_pct: 0,  exp_beats: 10,   exp_err: 1};
    rows[2] = '{len: 63,   rdy_pct: 70,  gap_pct: 20, exp_beats: 63,   exp_err: 1};
    rows[3] = '{len: 1518, rdy_pct: 100, gap_pct: 0,  exp_beats: 1518, exp_err: 0};
    rows[4] = '{len: 1519, rdy_pct: 90,  gap_pct: 10, exp_beats: 1518, exp_err: 1};
    rows[5] = '{len: 1,    rdy_pct: 50,  gap_pct: 50, exp_beats: 1,    exp_err: 1};
    rows[6] = '{len: 65,   rdy_pct: 60,  gap_pct: 30, exp_beats: 65,   exp_err: 0};
    rows[7] = '{len: 200,  rdy_pct: 50,  gap_pct: 0,  exp_beats: 200,  exp_err: 0};
    rows[8] = '{len: 120,  rdy_pct: 100, gap_pct: 40, exp_beats: 120,  exp_err: 0};
    rows[9] = '{len: 64,   rdy_pct: 20,  gap_pct: 0,  exp_beats: 64,   exp_err: 0};

    rrst_n = 1'b0; fifo_r_empty = 1'b1; m_ready = 1'b0; fifo_r_data = '0;
    repeat (2) @(negedge clk);
    fifo_r_empty = 1'b0;
    m_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    fifo_r_empty = 1'b1;
    rrst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rdy_pct = rows[i].rdy_pct;
      gap_pct = rows[i].gap_pct;
      f0 = frames_seen;
      first_en_cyc = -1;
      first_val_cyc = -1;
      add_frame(rows[i].len);
      drain(rows[i].len * 12 + 100);
      chk($sformatf("row%0d_frames", i), frames_seen - f0, 1);
      chk($sformatf("row%0d_beats", i), last_frame_beats, rows[i].exp_beats);
      chk($sformatf("row%0d_err", i), last_frame_err, rows[i].exp_err);
      if (i == 0) chk("first_latency", first_val_cyc - first_en_cyc, 2);
`ifdef RX_FRAME_READER_STATS_EN
      if (i == 1) chk("runt_err_cnt", err_cnt, 1);
`endif
    end

    // Oversize frame immediately followed by a clean frame
    rdy_pct = 100; gap_pct = 0;
    f0 = frames_seen;
    add_frame(1600);
    add_frame(100);
    drain(4000);
    chk("oversize_frames", frames_seen - f0, 2);
    chk("after_oversize_beats", last_frame_beats, 100);
    chk("after_oversize_err", last_frame_err, 0);

    // Reset at beat 30 of a frame, then a fresh frame
    add_frame(64);
    n = 0;
    while (fbeats < 30 && n < 500) begin
      step();
      n++;
    end
    chk("reached_beat30", fbeats, 30);
    @(negedge clk);
    rrst_n = 1'b0;
    fifo_r_empty = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midreset_hold_r_en", fifo_r_en, 0);
      chk("midreset_hold_valid", m_valid, 0);
    end
    @(negedge clk);
    fifo_r_empty = 1'b1;
    rrst_n = 1'b1;
    f0 = frames_seen;
    add_frame(64);
    drain(1000);
    chk("post_reset_frames", frames_seen - f0, 1);
    chk("post_reset_beats", last_frame_beats, 64);
    chk("post_reset_err", last_frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
